hilo_mdu: RTL and testbench

HILO_MDU -- requirements
Module: hilo_mdu

---
 rtl/hilo_mdu.sv | 166 ++++++++++++++++
 tb/tb_hilo_mdu.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: multicycle MULT/DIV (MUL_LAT/DIV_LAT cycles), MTHI/MTLO in one edge.
// Starts while busy are dropped; define HILO_MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module hilo_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hilo_sel,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

`ifdef HILO_MDU_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  logic [0:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  // Decode of the incoming request
  logic               w_in_mul;
  logic               w_in_div;
  logic [CW-1:0]      w_lat_m1;

  assign w_in_mul = (op == OP_MULT) || (op == OP_MULTU) ||
                    (MADD_EN && (op >= OP_MADD) && (op <= OP_MSUBU));
  assign w_in_div = (op == OP_DIV) || (op == OP_DIVU);
  assign w_lat_m1 = w_in_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);

  // Decode of the latched operation
  logic               w_r_signed;
  logic               w_r_div;
  logic               w_r_madd;
  logic               w_r_msub;

  assign w_r_signed = (r_op == OP_MULT) || (r_op == OP_DIV) ||
                      (r_op == OP_MADD) || (r_op == OP_MSUB);
  assign w_r_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_r_madd   = (r_op == OP_MADD) || (r_op == OP_MADDU);
  assign w_r_msub   = (r_op == OP_MSUB) || (r_op == OP_MSUBU);

  // Extending to 2*WIDTH first makes one multiplier serve signed and unsigned
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_mul_res;

  assign w_ext_a   = w_r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_ext_b   = w_r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod    = w_ext_a * w_ext_b;
  assign w_acc     = {r_hi, r_lo};
  assign w_mul_res = w_r_madd ? (w_acc + w_prod) :
                     w_r_msub ? (w_acc - w_prod) : w_prod;

  // Magnitude divide; MIN/-1 wraps back to MIN through the final negation
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_uq;
  logic [WIDTH-1:0]   w_ur;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_neg_a  = w_r_signed && r_a[WIDTH-1];
  assign w_neg_b  = w_r_signed && r_b[WIDTH-1];
  assign w_b_zero = (r_b == '0);
  assign w_abs_a  = w_neg_a ? -r_a : r_a;
  assign w_abs_b  = w_neg_b ? -r_b : r_b;
  assign w_uq     = w_b_zero ? '0 : (w_abs_a / w_abs_b);
  assign w_ur     = w_b_zero ? '0 : (w_abs_a % w_abs_b);
  assign w_quo    = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
  assign w_rem    = w_neg_a ? -w_ur : w_ur;

  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_res_hi = w_r_div ? w_rem : w_mul_res[2*WIDTH-1:WIDTH];
  assign w_res_lo = w_r_div ? w_quo : w_mul_res[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            if (w_in_mul || w_in_div) begin
              r_a     <= a;
              r_b     <= b;
              r_op    <= op;
              r_cnt   <= w_lat_m1;
              r_state <= S_RUN;
            end else if (op == OP_MTHI) begin
              r_hi <= a;
            end else if (op == OP_MTLO) begin
              r_lo <= a;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign out  = hilo_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu (WIDTH=32, MUL_LAT=5, DIV_LAT=10) with an HI/LO result scoreboard.
module tb_hilo_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hilo_sel;
  logic [31:0] out;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  hilo_mdu #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .hilo_sel (hilo_sel),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    hilo_sel = 1'b1;
    #1;
    h = out;
    hilo_sel = 1'b0;
    #1;
    l = out;
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] h;
    logic [31:0] l;
    read_hilo(h, l);
    chk({tag, "_hi"}, h, eh);
    chk({tag, "_lo"}, l, el);
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
    op    = 4'd0;
  endtask

  task automatic push(input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
  endtask

  // Counts busy cycles after the accepting edge, then compares the scoreboard head
  task automatic wait_done(input string tag, input int exp_busy);
    int nb;
    exp_t e;
    nb = 0;
    while (busy && nb < 200) begin
      nb++;
      step();
    end
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_hilo(tag, e.hi, e.lo);
    end else begin
      checks++;
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    step();
    chk({tag, "_done_clear"}, {63'd0, done}, 64'd0);
  endtask

  task automatic watch_no_done(input string tag, input int ncyc);
    int nd;
    nd = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (done) nd++;
      step();
    end
    chk({tag, "_no_done"}, 64'(nd), 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 4'd0;
    a        = '0;
    b        = '0;
    flush    = 1'b0;
    hilo_sel = 1'b0;

    step();
    step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk_hilo("rst", 32'h0, 32'h0);
    reset = 1'b0;
    step();

    // Signed and unsigned multiply of the same bit patterns
    push(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult", 5);

    push(32'h0000_0001, 32'hFFFF_FFFE);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu", 5);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 10);

    push(32'h0, 32'h0);
    issue(4'd4, 32'd7, 32'd0);
    wait_done("divu_zero", 10);

    push(32'h0, 32'h8000_0000);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10);

    push(32'h0000_0002, 32'h0000_000E);
    issue(4'd4, 32'd100, 32'd7);
    wait_done("divu", 10);

    // MTHI in idle writes at once with no busy or done
    issue(4'd5, 32'h0000_1234, 32'd0);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    chk("mthi_done", {63'd0, done}, 64'd0);
    chk_hilo("mthi", 32'h0000_1234, 32'h0000_000E);

    // Second start while busy is dropped
    push(32'h0, 32'd12);
    issue(4'd1, 32'd3, 32'd4);
    step();
    issue(4'd1, 32'd5, 32'd5);
    wait_done("mult_ignore", 3);
    watch_no_done("mult_ignore", 8);
    chk("mult_ignore_busy", {63'd0, busy}, 64'd0);

    // Flush mid-divide keeps the earlier MTLO value
    issue(4'd6, 32'h0000_0055, 32'd0);
    issue(4'd4, 32'd100, 32'd7);
    step();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    chk_hilo("flush", 32'h0, 32'h0000_0055);
    watch_no_done("flush", 12);

    // Flush on the same edge as an MTHI start
    start = 1'b1;
    op    = 4'd5;
    a     = 32'hDEAD_BEEF;
    flush = 1'b1;
    step();
    start = 1'b0;
    op    = 4'd0;
    flush = 1'b0;
    chk_hilo("flush_mthi", 32'h0, 32'h0000_0055);

    // Flush on the completion edge
    issue(4'd1, 32'd2, 32'd3);
    step();
    step();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_cmpl_busy", {63'd0, busy}, 64'd0);
    chk("flush_cmpl_done", {63'd0, done}, 64'd0);
    chk_hilo("flush_cmpl", 32'h0, 32'h0000_0055);

    // Multiply-accumulate ops
    issue(4'd5, 32'h0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
`ifdef HILO_MDU_MADD_EN
    push(32'h1, 32'h0);
    issue(4'd8, 32'd1, 32'd1);
    wait_done("maddu", 5);
    push(32'h0, 32'hFFFF_FFFF);
    issue(4'd10, 32'd1, 32'd1);
    wait_done("msubu", 5);
    push(32'h0, 32'hFFFF_FFFE);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    wait_done("madd", 5);
`else
    issue(4'd8, 32'd1, 32'd1);
    chk("maddu_off_busy", {63'd0, busy}, 64'd0);
    watch_no_done("maddu_off", 8);
    chk_hilo("maddu_off", 32'h0, 32'hFFFF_FFFF);
    issue(4'd9, 32'd1, 32'd1);
    chk("msub_off_busy", {63'd0, busy}, 64'd0);
`endif

    // Reset in the middle of a divide
    issue(4'd5, 32'h0000_0077, 32'd0);
    issue(4'd3, 32'd9, 32'd2);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    chk_hilo("rst_mid", 32'h0, 32'h0);
    watch_no_done("rst_mid", 14);

    // Reset overrides a same-edge start
    reset = 1'b1;
    start = 1'b1;
    op    = 4'd6;
    a     = 32'h0000_00AA;
    step();
    reset = 1'b0;
    start = 1'b0;
    op    = 4'd0;
    chk_hilo("rst_start", 32'h0, 32'h0);

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
